// File: rtl/sev_seg_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment driver.
package sev_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    // Active-low cathode pattern for one hex digit, DP bit returned unlit
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sev_seg_hex_decode.sv
// Combinational nibble + decimal point to active-low cathode pattern.
module sev_seg_hex_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    // Table lookup, then overlay the active-low DP bit
    always_comb begin
        o_seg         = hex_to_seg(i_nibble);
        o_seg[DP_BIT] = ~i_dp;
    end

endmodule

// File: rtl/sev_seg_mux_ctrl.sv
// Time-multiplexed N-digit seven-segment driver with PWM dimming and a frame-committed
// double buffer. Define SSEG_LZ_BLANK_EN to enable leading-zero suppression.
module sev_seg_mux_ctrl
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_LOG2 = 18,
    parameter int PWM_BITS   = 4
) (
    input  logic                    CLK100MHZ,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic                    frame_tick,
    output logic [NUM_DIGITS-1:0]   SSEG_AN,
    output logic [7:0]              SSEG_CA
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIGIT_LOG2-1:0]   r_slot;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_tick;
    logic [4*NUM_DIGITS-1:0] r_act_din, r_pend_din;
    logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank, r_pend_blank;
    logic                    r_pend_full;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_ca;

    logic                    w_tc, w_wrap, w_accept, w_commit, w_pwm_on, w_lit;
    logic [NUM_DIGITS-1:0]   w_lz_mask, w_blank_eff;
    logic [3:0]              w_nibble;
    logic [7:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [7:0]              w_ca_next;

    assign w_tc     = &r_slot;
    assign w_wrap   = w_tc && (r_idx == LAST_IDX);
    assign w_accept = din_valid && !r_pend_full;
    assign w_commit = w_wrap && r_pend_full;

    // Free-running slot counter, digit index and end-of-frame pulse
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            r_slot       <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_slot       <= r_slot + DIGIT_LOG2'(1);
            r_frame_tick <= w_wrap;
            if (w_wrap) begin
                r_idx <= '0;
            end else if (w_tc) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    // Pending buffer fills on handshake; active buffer only changes at the frame wrap
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            r_pend_din   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_full  <= 1'b0;
            r_act_din    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
        end else if (w_commit) begin
            r_act_din    <= r_pend_din;
            r_act_dp     <= r_pend_dp;
            r_act_blank  <= r_pend_blank;
            r_pend_full  <= 1'b0;
        end else if (w_accept) begin
            r_pend_din   <= din;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_pend_full  <= 1'b1;
        end else begin
            r_pend_full  <= r_pend_full;
        end
    end

    assign din_ready = !r_pend_full;

`ifdef SSEG_LZ_BLANK_EN
    // A digit is suppressed when it and every digit above it hold zero; digit 0 never is
    always_comb begin
        logic w_zero_run;
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run   = w_zero_run & (r_act_din[4*k +: 4] == 4'h0);
            w_lz_mask[k] = w_zero_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    assign w_blank_eff = r_act_blank | w_lz_mask;
    assign w_pwm_on    = (r_slot[DIGIT_LOG2-1 -: PWM_BITS] < brightness) || (&brightness);
    assign w_lit       = !w_blank_eff[r_idx] && w_pwm_on;
    assign w_nibble    = r_act_din[{r_idx, 2'b00} +: 4];

    sev_seg_hex_decode u_decode (
        .i_nibble (w_nibble),
        .i_dp     (r_act_dp[r_idx]),
        .o_seg    (w_seg)
    );

    // Select the lit anode and its cathodes, or go fully dark
    always_comb begin
        w_an_next = '1;
        w_ca_next = SEG_BLANK;
        if (w_lit) begin
            w_an_next[r_idx] = 1'b0;
            w_ca_next        = w_seg;
        end else begin
            w_an_next = '1;
            w_ca_next = SEG_BLANK;
        end
    end

    // Registered pin drivers
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            r_an <= '1;
            r_ca <= SEG_BLANK;
        end else begin
            r_an <= w_an_next;
            r_ca <= w_ca_next;
        end
    end

    assign SSEG_AN    = r_an;
    assign SSEG_CA    = r_ca;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sev_seg_mux_ctrl.sv
// Scoreboard bench for sev_seg_mux_ctrl with 4 digits, 16-cycle slots, 2-bit brightness.
module tb_sev_seg_mux_ctrl;

    logic        CLK100MHZ = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        din_valid = 1'b0;
    logic [1:0]  brightness = 2'd0;
    logic        din_ready, frame_tick;
    logic [3:0]  SSEG_AN;
    logic [7:0]  SSEG_CA;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ca;
        logic       ft;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state: cycles since reset release plus the two buffers
    int          m_cyc = 0;
    logic [15:0] m_act_din = 16'h0, m_pend_din = 16'h0;
    logic [3:0]  m_act_dp = 4'h0, m_pend_dp = 4'h0;
    logic [3:0]  m_act_blank = 4'h0, m_pend_blank = 4'h0;
    logic        m_pend_full = 1'b0;

    sev_seg_mux_ctrl #(.NUM_DIGITS(4), .DIGIT_LOG2(4), .PWM_BITS(2)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .rst        (rst),
        .din        (din),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .brightness (brightness),
        .frame_tick (frame_tick),
        .SSEG_AN    (SSEG_AN),
        .SSEG_CA    (SSEG_CA)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    function automatic exp_t dut_obs();
        return {SSEG_AN, SSEG_CA, frame_tick, din_ready};
    endfunction

    // Predict the outputs of the coming edge, push them, advance the model, then clock
    task automatic tick();
        exp_t       e;
        int         slot, idx;
        logic       on;
        logic [3:0] nib;
        if (rst) begin
            m_cyc = 0; m_act_din = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'h0;
            m_pend_full = 1'b0;
            e = {4'hF, 8'hFF, 1'b0, 1'b1};
        end else begin
            slot = m_cyc % 16;
            idx  = (m_cyc / 16) % 4;
            nib  = m_act_din[4*idx +: 4];
            on   = !m_act_blank[idx] && (((slot / 4) < int'(brightness)) || (brightness == 2'd3));
`ifdef SSEG_LZ_BLANK_EN
            if (idx > 0 && (m_act_din >> (4*idx)) == 16'h0) on = 1'b0;
`endif
            e.an = 4'hF;
            e.ca = 8'hFF;
            if (on) begin
                e.an[idx] = 1'b0;
                e.ca = {~m_act_dp[idx], seg_tab[nib][6:0]};
            end
            e.ft = (m_cyc % 64 == 63);
            if (e.ft && m_pend_full) begin
                m_act_din = m_pend_din; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
                m_pend_full = 1'b0;
            end else if (din_valid && !m_pend_full) begin
                m_pend_din = din; m_pend_dp = dp_in; m_pend_blank = blank_in;
                m_pend_full = 1'b1;
            end
            e.rdy = !m_pend_full;
            m_cyc++;
        end
        sb_q.push_back(e);
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%h exp=%h", i, dut_obs(), e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        exp_t e;
        int   ticks = 0;
        brightness = 2'd3;
        for (int i = 0; i < 128; i++) begin
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL scan cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
            if (frame_tick) ticks++;
        end
        n_tests++;
        if (ticks !== 2) begin
            n_fail++;
            $display("FAIL scan_ticks got=%0d exp=2", ticks);
        end
    endtask

    task automatic test_update();
        exp_t e;
        while (m_cyc % 64 != 20) begin
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL update_pre cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
        end
        din = 16'h12AF; dp_in = 4'b0010; din_valid = 1'b1;
        for (int i = 0; i < 140; i++) begin
            tick();
            din_valid = 1'b0;
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL update cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        din = 16'h1111; dp_in = 4'b0001; din_valid = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (i == 0) begin din = 16'h2C3D; dp_in = 4'b1000; end
            if (i == 79) din_valid = 1'b0;
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
        end
    endtask

    task automatic test_pwm();
        exp_t e;
        int   lit0;
        int   lit_any;
        lit0 = 0;
        lit_any = 0;
        brightness = 2'd1;
        for (int i = 0; i < 64; i++) begin
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL pwm1 cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
            if (SSEG_AN == 4'hE) lit0++;
        end
        n_tests++;
        if (lit0 !== 4) begin
            n_fail++;
            $display("FAIL pwm1_duty got=%0d exp=4", lit0);
        end
        brightness = 2'd0;
        for (int i = 0; i < 64; i++) begin
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL pwm0 cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
            if (SSEG_AN != 4'hF || SSEG_CA != 8'hFF) lit_any++;
        end
        n_tests++;
        if (lit_any !== 0) begin
            n_fail++;
            $display("FAIL pwm0_dark got=%0d exp=0", lit_any);
        end
        brightness = 2'd3;
    endtask

    task automatic test_blank();
        exp_t e;
        din = 16'h8888; dp_in = 4'h0; blank_in = 4'b0100; din_valid = 1'b1;
        for (int i = 0; i < 160; i++) begin
            tick();
            din_valid = 1'b0;
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL blank cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
        end
        blank_in = 4'h0;
    endtask

`ifdef SSEG_LZ_BLANK_EN
    task automatic test_lz();
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            din = (p == 0) ? 16'h0005 : 16'h0000; dp_in = 4'b0010; din_valid = 1'b1;
            for (int i = 0; i < 140; i++) begin
                tick();
                din_valid = 1'b0;
                e = sb_q.pop_front();
                n_tests++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL lz p=%0d cyc=%0d got=%h exp=%h", p, m_cyc - 1, dut_obs(), e);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        exp_t e;
        brightness = 2'd3;
        din = 16'h4321; dp_in = 4'hF; din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            din_valid = 1'b0;
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (dut_obs() !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=%h", dut_obs(), {4'hF, 8'hFF, 1'b0, 1'b1});
        end
        tick();
        e = sb_q.pop_front();
        rst = 1'b0;
        n_tests++;
        if (dut_obs() !== e) begin
            n_fail++;
            $display("FAIL reset_mid_hold got=%h exp=%h", dut_obs(), e);
        end
        for (int i = 0; i < 140; i++) begin
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", m_cyc - 1, dut_obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_back_to_back();
        test_pwm();
        test_blank();
`ifdef SSEG_LZ_BLANK_EN
        test_lz();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
